// File: rtl/riscv_pkg.sv
// Shared definitions for the write-back / register-file slice of the pipeline.
// Reset convention across this slice: asynchronous, active-low.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int CNT_W      = 64;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: one write port, two combinational read ports with
// write-first bypass, and x0 hard-wired to zero.
module regfile_2r1w
    import riscv_pkg::*;
#(
    parameter int W      = XLEN,
    parameter int NR     = NREGS,
    parameter int AW     = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [W-1:0]  o_rdata1,
    output logic [W-1:0]  o_rdata2
);

    // Only x1..x(NR-1) are stored; x0 has no storage at all.
    logic [W-1:0] r_regs [1:NR-1];
    logic         w_wvalid;

    assign w_wvalid = i_we && (i_waddr != '0);

    // Storage update: cleared on reset, otherwise written only under a qualified strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NR; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wvalid) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read port 1: x0 reads zero, a same-cycle write to the same register wins.
    always_comb begin
        o_rdata1 = '0;
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (w_wvalid && (i_raddr1 == i_waddr)) begin
            o_rdata1 = i_wdata;
        end else begin
            o_rdata1 = r_regs[i_raddr1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        o_rdata2 = '0;
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (w_wvalid && (i_raddr2 == i_waddr)) begin
            o_rdata2 = i_wdata;
        end else begin
            o_rdata2 = r_regs[i_raddr2];
        end
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the write-back value, qualifies the register-file
// write, hosts the register file and counts retired instructions.
module wb_regfile_stage
    import riscv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter int CNT_W_P = CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [1:0]            wb_selb3,
    input  logic                  rf_enb3,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN_P-1:0]     alu_result,
    input  logic [XLEN_P-1:0]     load_data,
    input  logic [XLEN_P-1:0]     pc_plus4,
    input  logic [XLEN_P-1:0]     csr_rdata,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN_P-1:0]     rs1_data,
    output logic [XLEN_P-1:0]     rs2_data,
    output logic [XLEN_P-1:0]     wb_data,
    output logic                  wb_we,
    output logic [CNT_W_P-1:0]    instret
);

    logic [XLEN_P-1:0]  w_wb_data;
    logic               w_wb_we;
    logic [CNT_W_P-1:0] r_instret;

    // Write-back source mux; active even when no write happens.
    always_comb begin
        w_wb_data = alu_result;
        case (wb_sel_e'(wb_selb3))
            WB_ALU:  w_wb_data = alu_result;
            WB_LOAD: w_wb_data = load_data;
            WB_PC4:  w_wb_data = pc_plus4;
            WB_CSR:  w_wb_data = csr_rdata;
            default: w_wb_data = alu_result;
        endcase
    end

    assign w_wb_we = wb_valid && rf_enb3 && (rd_addr != '0);

    // Retired-instruction counter: every valid WB instruction retires, wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (wb_valid) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    regfile_2r1w #(
        .W  (XLEN_P),
        .NR (NREGS_P),
        .AW (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wb_we),
        .i_waddr  (rd_addr),
        .i_wdata  (w_wb_data),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data)
    );

    assign wb_data = w_wb_data;
    assign wb_we   = w_wb_we;
    assign instret = r_instret;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage.
module tb_wb_regfile_stage;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [1:0]  wb_selb3;
    logic        rf_enb3;
    logic [4:0]  rd_addr;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
    logic [31:0] csr_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [63:0] instret;

    int checks;
    int failures;

    wb_regfile_stage dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_selb3   (wb_selb3),
        .rf_enb3    (rf_enb3),
        .rd_addr    (rd_addr),
        .alu_result (alu_result),
        .load_data  (load_data),
        .pc_plus4   (pc_plus4),
        .csr_rdata  (csr_rdata),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic en, input logic [4:0] rd,
                                 input logic [4:0] a1, input logic [4:0] a2);
        wb_valid = v;
        wb_selb3 = sel;
        rf_enb3  = en;
        rd_addr  = rd;
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] selVals [4];
        checks   = 0;
        failures = 0;
        selVals[0] = 32'h11;
        selVals[1] = 32'h22;
        selVals[2] = 32'h33;
        selVals[3] = 32'h44;

        rst        = 1'b0;
        alu_result = 32'h11;
        load_data  = 32'h22;
        pc_plus4   = 32'h33;
        csr_rdata  = 32'h44;
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 5'd5, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_instret", instret, 64'd0);
        checkOutput("reset_x5", {32'd0, rs1_data}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Mux and write into x5 with each source in turn
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 2'(i), 1'b1, 5'd5, 5'd5, 5'd0);
            checkOutput($sformatf("mux_sel%0d", i), {32'd0, wb_data}, {32'd0, selVals[i]});
            checkOutput($sformatf("we_sel%0d", i), {63'd0, wb_we}, 64'd1);
            stepEdge();
            applyStimulus(1'b0, 2'(i), 1'b1, 5'd5, 5'd5, 5'd0);
            checkOutput($sformatf("x5_sel%0d", i), {32'd0, rs1_data}, {32'd0, selVals[i]});
            checkOutput($sformatf("instret_sel%0d", i), instret, 64'(i + 1));
        end

        // Write to x0 is dropped but still retires
        @(negedge clk);
        alu_result = 32'hDEADBEEF;
        applyStimulus(1'b1, 2'b00, 1'b1, 5'd0, 5'd0, 5'd5);
        checkOutput("x0_we", {63'd0, wb_we}, 64'd0);
        checkOutput("x0_read", {32'd0, rs1_data}, 64'd0);
        stepEdge();
        applyStimulus(1'b0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd5);
        checkOutput("x0_read_after", {32'd0, rs1_data}, 64'd0);
        checkOutput("x0_x5_kept", {32'd0, rs2_data}, 64'h44);
        checkOutput("x0_instret", instret, 64'd5);

        // Bypass: both ports see the in-flight value before the edge
        @(negedge clk);
        alu_result = 32'hCAFEF00D;
        applyStimulus(1'b0, 2'b00, 1'b1, 5'd7, 5'd7, 5'd7);
        checkOutput("byp_no_we_x7", {32'd0, rs1_data}, 64'd0);
        applyStimulus(1'b1, 2'b00, 1'b1, 5'd7, 5'd7, 5'd7);
        checkOutput("byp_rs1", {32'd0, rs1_data}, 64'hCAFEF00D);
        checkOutput("byp_rs2", {32'd0, rs2_data}, 64'hCAFEF00D);
        stepEdge();
        applyStimulus(1'b0, 2'b00, 1'b1, 5'd7, 5'd7, 5'd7);
        checkOutput("stored_rs1", {32'd0, rs1_data}, 64'hCAFEF00D);
        checkOutput("stored_rs2", {32'd0, rs2_data}, 64'hCAFEF00D);
        checkOutput("byp_instret", instret, 64'd6);

        // Bubble: enable without valid
        @(negedge clk);
        alu_result = 32'h99;
        applyStimulus(1'b0, 2'b00, 1'b1, 5'd9, 5'd9, 5'd7);
        checkOutput("bubble_we", {63'd0, wb_we}, 64'd0);
        stepEdge();
        checkOutput("bubble_x9", {32'd0, rs1_data}, 64'd0);
        checkOutput("bubble_instret", instret, 64'd6);

        // Store-like retire: valid without enable counts but does not write
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 1'b0, 5'd9, 5'd9, 5'd7);
        checkOutput("store_we", {63'd0, wb_we}, 64'd0);
        stepEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd9, 5'd9, 5'd7);
        checkOutput("store_x9", {32'd0, rs1_data}, 64'd0);
        checkOutput("store_instret", instret, 64'd7);

        // Asynchronous reset mid-run clears immediately
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 5'd5, 5'd7);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("areset_x5", {32'd0, rs1_data}, 64'd0);
        checkOutput("areset_x7", {32'd0, rs2_data}, 64'd0);
        checkOutput("areset_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        checkOutput("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
        stepEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("wrap_zero", instret, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
